// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic pipeline register for the slots between CPU stages (FI/ID, ID/EX,
//   EX/MA, MA/WB). It carries a datapath payload and a control bundle under a
//   valid/ready handshake. A flush squashes everything the stage holds. An
//   empty slot always presents NOP_CTRL, so no RegWr/MemWr leaks downstream.
//
//   SKID != 0 : two-entry buffer (main + skid). in_ready comes from a
//               register, which cuts the combinational stall path from
//               out_ready back to in_ready.
//   SKID == 0 : one register. in_ready = !out_valid | out_ready
//               (combinational).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   flush      in   squash all held entries (sampled on the rising edge)
//   in_valid   in   upstream payload present
//   in_ready   out  stage accepts; transfer when in_valid & in_ready
//   in_data    in   upstream payload [DATA_W]
//   in_ctrl    in   upstream control bundle [CTRL_W]
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts; transfer when out_valid & out_ready
//   out_data   out  head payload [DATA_W]
//   out_ctrl   out  head control [CTRL_W]; NOP_CTRL while out_valid = 0
//   occupancy  out  entries held (0..2; at most 1 when SKID == 0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 10,
    parameter int                 SKID     = 1,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // The state encoding equals the number of held entries. This lets
    // occupancy be driven straight from the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : NOP_CTRL;
    assign occupancy = state_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // The register holds "not full after this edge". When the stage
            // is full, a downstream pop does not reopen the input until the
            // next cycle. This is the timing cut the skid buffer exists for.
            logic in_ready_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = in_ready_q & ~flush & ~rst;
        end else begin : g_noskid
            assign in_ready = (~out_valid | out_ready) & ~flush & ~rst;
        end
    endgenerate

    // Next-state and datapath steering
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // A squash drops every entry. Any output transfer in this cycle
            // has already completed downstream, so nothing is replayed.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer) begin
                        // Only reachable with a skid buffer. Without one,
                        // in_ready at ONE implies out_ready.
                        if (SKID != 0) begin
                            state_d     = ST_FULL;
                            skid_data_d = in_data;
                            skid_ctrl_d = in_ctrl;
                        end
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share the clock, reset and flush:
//   dut_a : SKID=1, NOP_CTRL=0
//   dut_b : SKID=0, NOP_CTRL=10'h2A5
// The reference model is a queue of {ctrl, data} per instance.
// Expected in_ready follows directly from the queue depth and the handshake
// rules.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int              DW    = 32;
    localparam int              CW    = 10;
    localparam logic [CW-1:0]   NOP_A = '0;
    localparam logic [CW-1:0]   NOP_B = 10'h2A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]    a_occ;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .NOP_CTRL(NOP_A)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .NOP_CTRL(NOP_B)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occ)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // A skid stage accepts while fewer than two entries are held.
    function automatic logic exp_a_ready();
        return !rst && !flush && (qa.size() < 2);
    endfunction

    // A single-register stage accepts when empty or when the head leaves now.
    function automatic logic exp_b_ready();
        return !rst && !flush && (qb.size() == 0 || b_out_ready);
    endfunction

    // Advance one clock edge and apply the same edge to both FIFO models.
    task automatic tick();
        logic a_in, a_out, b_in, b_out;
        a_in  = a_in_valid && exp_a_ready();
        a_out = (qa.size() != 0) && a_out_ready;
        b_in  = b_in_valid && exp_b_ready();
        b_out = (qb.size() != 0) && b_out_ready;
        @(posedge clk);
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out) void'(qa.pop_front());
            if (a_in)  qa.push_back({a_in_ctrl, a_in_data});
            if (b_out) void'(qb.pop_front());
            if (b_in)  qb.push_back({b_in_ctrl, b_in_data});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        tests_run++; if (a_occ !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", a_occ); end
        tests_run++; if (a_out_ctrl !== NOP_A) begin tests_failed++; $display("FAIL reset_out_ctrl: got %h want %h", a_out_ctrl, NOP_A); end
        tests_run++; if (a_out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready_a: got %b want 0", a_in_ready); end
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready_b: got %b want 0", b_in_ready); end
        tests_run++; if (b_out_ctrl !== NOP_B) begin tests_failed++; $display("FAIL reset_out_ctrl_b: got %h want %h", b_out_ctrl, NOP_B); end
        rst = 1'b0;
        #1;
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_a: got %b want 1", a_in_ready); end
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_b: got %b want 1", b_in_ready); end
    endtask

    task automatic test_stream();
        logic [CW-1:0] ctl [8];
        logic          exp_v;
        a_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                a_in_valid = 1'b1;
                a_in_data  = DW'(k + 1);
                a_in_ctrl  = CW'($urandom);
                ctl[k]     = a_in_ctrl;
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            exp_v = (k >= 1) && (k <= 8);
            tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, a_in_ready); end
            tests_run++; if (a_out_valid !== exp_v) begin tests_failed++; $display("FAIL stream_out_valid k=%0d: got %b want %b", k, a_out_valid, exp_v); end
            if (exp_v) begin
                tests_run++; if (a_out_data !== DW'(k)) begin tests_failed++; $display("FAIL stream_out_data k=%0d: got %h want %h", k, a_out_data, DW'(k)); end
                tests_run++; if (a_out_ctrl !== ctl[k-1]) begin tests_failed++; $display("FAIL stream_out_ctrl k=%0d: got %h want %h", k, a_out_ctrl, ctl[k-1]); end
            end
            tests_run++; if (a_occ > 2'd1) begin tests_failed++; $display("FAIL stream_occupancy k=%0d: got %0d want <=1", k, a_occ); end
            tick();
        end
    endtask

    task automatic test_stall();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = 32'h11; a_in_ctrl = 10'h003;
        #1;
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_accept_a: got %b want 1", a_in_ready); end
        tick();
        a_in_data = 32'h22; a_in_ctrl = 10'h005;
        #1;
        tests_run++; if (a_occ !== 2'd1) begin tests_failed++; $display("FAIL stall_occ1: got %0d want 1", a_occ); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_accept_b: got %b want 1", a_in_ready); end
        tick();
        a_in_data = 32'h44; a_in_ctrl = 10'h007;
        #1;
        tests_run++; if (a_occ !== 2'd2) begin tests_failed++; $display("FAIL stall_occ2: got %0d want 2", a_occ); end
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready_full: got %b want 0", a_in_ready); end
        tests_run++; if (a_out_data !== 32'h11) begin tests_failed++; $display("FAIL stall_head: got %h want 11", a_out_data); end
        tick();
        a_in_valid = 1'b0;
        #1;
        tests_run++; if (a_out_data !== 32'h11) begin tests_failed++; $display("FAIL stall_head_stable: got %h want 11", a_out_data); end
        tests_run++; if (a_occ !== 2'd2) begin tests_failed++; $display("FAIL stall_refused: got occ %0d want 2", a_occ); end
        a_out_ready = 1'b1;
        #1;
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready_registered: got %b want 0", a_in_ready); end
        tick();
        #1;
        tests_run++; if (a_out_data !== 32'h22) begin tests_failed++; $display("FAIL stall_second: got %h want 22", a_out_data); end
        tests_run++; if (a_occ !== 2'd1) begin tests_failed++; $display("FAIL stall_drain_occ: got %0d want 1", a_occ); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_reopen: got %b want 1", a_in_ready); end
        tick();
        #1;
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_empty_valid: got %b want 0", a_out_valid); end
        tests_run++; if (a_out_ctrl !== NOP_A) begin tests_failed++; $display("FAIL stall_empty_ctrl: got %h want %h", a_out_ctrl, NOP_A); end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = 32'hA1; a_in_ctrl = 10'h201;
        tick();
        a_in_data = 32'hA2; a_in_ctrl = 10'h202;
        tick();
        a_in_data = 32'h33; a_in_ctrl = 10'h233; flush = 1'b1;
        #1;
        tests_run++; if (a_occ !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_occ: got %0d want 2", a_occ); end
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready_a: got %b want 0", a_in_ready); end
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready_b: got %b want 0", b_in_ready); end
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        #1;
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b want 0", a_out_valid); end
        tests_run++; if (a_out_ctrl !== NOP_A) begin tests_failed++; $display("FAIL flush_out_ctrl: got %h want %h", a_out_ctrl, NOP_A); end
        tests_run++; if (a_occ !== 2'd0) begin tests_failed++; $display("FAIL flush_occ: got %0d want 0", a_occ); end
        // A flush with one entry held must still block the input.
        a_in_valid = 1'b1; a_in_data = 32'h55; a_in_ctrl = 10'h155;
        tick();
        a_in_data = 32'h33; a_in_ctrl = 10'h233; flush = 1'b1;
        #1;
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_one_in_ready: got %b want 0", a_in_ready); end
        tick();
        flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_leak k=%0d: got valid %b data %h want 0", k, a_out_valid, a_out_data); end
            tick();
        end
    endtask

    task automatic test_bubble();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1; a_in_data = $urandom; a_in_ctrl = 10'b1000000110;
        tick();
        a_in_valid = 1'b0;
        #1;
        tests_run++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 10'b1000000110) begin tests_failed++; $display("FAIL bubble_live: got v=%b ctrl=%b want v=1 ctrl=1000000110", a_out_valid, a_out_ctrl); end
        tick();
        #1;
        tests_run++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 10'b0) begin tests_failed++; $display("FAIL bubble_nop: got v=%b ctrl=%b want v=0 ctrl=0", a_out_valid, a_out_ctrl); end
    endtask

    task automatic test_random_skid1();
        ent_t          head;
        logic          ev;
        logic [CW-1:0] ectrl;
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = ($urandom_range(0, 9) < 7);
            a_out_ready = ($urandom_range(0, 9) < 6);
            a_in_data   = $urandom;
            a_in_ctrl   = CW'($urandom);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            ev    = (qa.size() != 0);
            head  = ev ? qa[0] : '0;
            ectrl = ev ? head.ctrl : NOP_A;
            tests_run++; if (a_in_ready !== exp_a_ready()) begin tests_failed++; $display("FAIL rnd1_in_ready c=%0d: got %b want %b", c, a_in_ready, exp_a_ready()); end
            tests_run++; if (a_out_valid !== ev) begin tests_failed++; $display("FAIL rnd1_out_valid c=%0d: got %b want %b", c, a_out_valid, ev); end
            tests_run++; if (a_out_ctrl !== ectrl) begin tests_failed++; $display("FAIL rnd1_out_ctrl c=%0d: got %h want %h", c, a_out_ctrl, ectrl); end
            tests_run++; if (a_occ !== 2'(qa.size())) begin tests_failed++; $display("FAIL rnd1_occupancy c=%0d: got %0d want %0d", c, a_occ, qa.size()); end
            if (ev) begin
                tests_run++; if (a_out_data !== head.data) begin tests_failed++; $display("FAIL rnd1_out_data c=%0d: got %h want %h", c, a_out_data, head.data); end
            end
            tick();
        end
        flush = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic test_random_skid0();
        ent_t          head;
        logic          ev;
        logic [CW-1:0] ectrl;
        for (int c = 0; c < 400; c++) begin
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_out_ready = ($urandom_range(0, 1) == 1);
            b_in_data   = $urandom;
            b_in_ctrl   = CW'($urandom);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            ev    = (qb.size() != 0);
            head  = ev ? qb[0] : '0;
            ectrl = ev ? head.ctrl : NOP_B;
            tests_run++; if (b_in_ready !== exp_b_ready()) begin tests_failed++; $display("FAIL rnd0_in_ready c=%0d: got %b want %b", c, b_in_ready, exp_b_ready()); end
            tests_run++; if (b_out_valid !== ev) begin tests_failed++; $display("FAIL rnd0_out_valid c=%0d: got %b want %b", c, b_out_valid, ev); end
            tests_run++; if (b_out_ctrl !== ectrl) begin tests_failed++; $display("FAIL rnd0_out_ctrl c=%0d: got %h want %h", c, b_out_ctrl, ectrl); end
            tests_run++; if (b_occ !== 2'(qb.size())) begin tests_failed++; $display("FAIL rnd0_occupancy c=%0d: got %0d want %0d", c, b_occ, qb.size()); end
            if (ev) begin
                tests_run++; if (b_out_data !== head.data) begin tests_failed++; $display("FAIL rnd0_out_data c=%0d: got %h want %h", c, b_out_data, head.data); end
            end
            tick();
        end
        flush = 1'b0; b_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_ctrl = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_ctrl = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_random_skid1();
        test_random_skid0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
